mem_slave: RTL and testbench
============================

MEM_SLAVE -- requirements
Module: mem_slave

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, which sets the number of words (need not be a power of 2).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), which sets the address width.
REQ-004 The block SHALL have parameter RD_LATENCY, default 2, which sets the number of wait cycles between read acceptance and data return (legal range 1..15).
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port valid_i, input, 1 bit: request valid.
REQ-008 The block SHALL have port wr_rd_i, input, 1 bit: request type, 1 = write, 0 = read.
REQ-009 The block SHALL have port addr_i, input, ADDR_WIDTH bits: word address.
REQ-010 The block SHALL have port wr_data_i, input, WIDTH bits: write data.
REQ-011 The block SHALL have port ready_o, output, 1 bit: the block can accept a request this cycle.
REQ-012 The block SHALL have port rd_data_o, output, WIDTH bits: read data, qualified by rd_valid_o.
REQ-013 The block SHALL have port rd_valid_o, output, 1 bit: a one-cycle pulse marking returned read data.
REQ-014 The block SHALL have port err_o, output, 1 bit: a one-cycle pulse marking an out-of-range access.

Function
REQ-015 A request SHALL be accepted on the rising edge where valid_i && ready_o; inputs are ignored in all other cycles.
REQ-016 The FSM SHALL have states IDLE and RD_WAIT; ready_o SHALL be 1 in IDLE and 0 in RD_WAIT (registered outputs, no valid->ready combinational path).
REQ-017 An accepted write SHALL update mem[addr_i] with wr_data_i at the accepting edge; the state stays IDLE, so back-to-back writes proceed at one per cycle.
REQ-018 An accepted read SHALL capture addr_i and move IDLE->RD_WAIT, loading a down-counter with RD_LATENCY-1.
REQ-019 In RD_WAIT the counter SHALL decrement each cycle; at zero the block SHALL load rd_data_o with mem[captured addr], pulse rd_valid_o for 1 cycle, and return to IDLE, with ready_o = 1 in that same cycle.
REQ-020 Read latency SHALL be exactly RD_LATENCY+1 cycles from the accepting edge to the rd_valid_o cycle; ready_o SHALL be low for exactly RD_LATENCY cycles.
REQ-021 rd_data_o SHALL hold its last value until the next read completes.
REQ-022 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-023 For addr_i >= DEPTH, a write SHALL leave memory unchanged and pulse err_o in the cycle after acceptance.
REQ-024 For addr_i >= DEPTH, a read SHALL follow normal timing, return rd_data_o = 0, and pulse err_o together with rd_valid_o.
REQ-025 Changes to valid_i while ready_o = 0 SHALL have no effect; no request is queued.

Reset
REQ-026 Asserting rst_i low SHALL immediately force: state IDLE, counter 0, ready_o 0, rd_valid_o 0, err_o 0, rd_data_o 0.
REQ-027 ready_o SHALL rise at the first rising clock edge after rst_i deasserts.
REQ-028 All memory words SHALL be cleared to 0 on reset.
REQ-029 A reset during RD_WAIT SHALL abort the read with no rd_valid_o pulse.

Structure
REQ-030 Shared package mem_pkg SHALL hold WIDTH/DEPTH defaults, the ADDR_WIDTH derivation and the FSM state enum (IDLE, RD_WAIT).
REQ-031 Storage SHALL be a sub-module mem_array: synchronous write port, combinational read port, async active-low clear.
REQ-032 The FSM, counter and output registers SHALL reside in mem_slave.

Verification
REQ-033 Write 0xA5A5 to addr 5, then read addr 5 -> rd_valid_o exactly 3 cycles after read acceptance with rd_data_o = 0xA5A5; ready_o low for 2 cycles.
REQ-034 Write every addr 0..63 with data = addr*3 back-to-back, then read all -> ready_o stays high during the writes and every read matches.
REQ-035 Drive valid_i high throughout a read's RD_WAIT with a different addr -> only one read completes and the memory is unchanged.
REQ-036 With DEPTH = 48, write addr 50, then read addr 50 -> err_o pulses both times, rd_data_o = 0, and addr 50 mod 48 is unchanged.
REQ-037 Assert rst_i low one cycle into RD_WAIT -> no rd_valid_o pulse, all outputs 0, and a read of any address afterwards returns 0.
REQ-038 Write 0x1234 to addr 7 and read addr 7 in the next cycle -> returns 0x1234.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the mem_slave word memory: size defaults and FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_RD_LATENCY = 2;

  // Wide enough for the largest legal read latency (15).
  localparam int CNT_WIDTH = 4;

  // Address width for a given word count; never below one bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write port, combinational read port, async clear to zero.
// Latency: a write lands at the clock edge; a read is visible in the same cycle.
// Backpressure: none; out-of-range writes are dropped and out-of-range reads return 0.
module mem_array
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = addr_bits(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  // DEPTH need not be a power of two, so the top of the address range can be empty.
  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok = ({1'b0, wr_addr} < DEPTH_V);
  assign rd_ok = ({1'b0, rd_addr} < DEPTH_V);

  // Storage: whole array cleared on reset, one word written per cycle otherwise.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_ok ? mem[rd_addr] : '0;

endmodule

// File: rtl/mem_slave.sv
// Single-port memory slave: one request per accepted valid/ready handshake, writes and reads.
// Latency: write lands at the accepting edge; read data returns RD_LATENCY+1 cycles after acceptance.
// Backpressure: ready_o is low for RD_LATENCY cycles while a read is pending; requests are never queued.
module mem_slave
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = addr_bits(DEPTH),
  // Legal range 1..15 (counter is CNT_WIDTH bits).
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_V  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_LOAD = CNT_WIDTH'(RD_LATENCY - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;
  logic                   ready_q, ready_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   err_q, err_d;
  logic [WIDTH-1:0]       rd_data_q, rd_data_d;

  logic                   accept;
  logic                   req_in_range;
  logic                   raddr_in_range;
  logic                   mem_wr_en;
  logic [WIDTH-1:0]       mem_rd_data;

  // ready_o is a flop, so acceptance never depends combinationally on valid_i.
  assign accept         = valid_i && ready_q;
  assign req_in_range   = ({1'b0, addr_i}  < DEPTH_V);
  assign raddr_in_range = ({1'b0, raddr_q} < DEPTH_V);

  mem_array #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (mem_wr_en),
    .wr_addr (addr_i),
    .wr_data (wr_data_i),
    .rd_addr (raddr_q),
    .rd_data (mem_rd_data)
  );

  // Next-state and next-output decode for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    raddr_d    = raddr_q;
    ready_d    = ready_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    rd_data_d  = rd_data_q;
    mem_wr_en  = 1'b0;

    case (state_q)
      IDLE: begin
        // Coming out of reset ready_q is 0; this raises it at the first edge.
        ready_d = 1'b1;
        if (accept) begin
          if (wr_rd_i) begin
            mem_wr_en = req_in_range;
            err_d     = !req_in_range;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_LOAD;
            raddr_d = addr_i;
            ready_d = 1'b0;
          end
        end
      end

      RD_WAIT: begin
        ready_d = 1'b0;
        if (cnt_q == '0) begin
          // Out-of-range reads return zero from the array and flag err_o alongside the data.
          state_d    = IDLE;
          rd_valid_d = 1'b1;
          rd_data_d  = mem_rd_data;
          err_d      = !raddr_in_range;
          ready_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any pending read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      raddr_q    <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      raddr_q    <= raddr_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign ready_o    = ready_q;
  assign rd_valid_o = rd_valid_q;
  assign err_o      = err_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_mem_slave.sv
// Bench for mem_slave: a default instance (DEPTH 64) and a DEPTH 48 instance share one stimulus.
// Read results are checked against a scoreboard filled when each read is issued.
// Timing, backpressure, out-of-range and reset corner cases are checked by hand-written sequences.
module tb_mem_slave;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        wr_rd_i = 1'b0;
  logic [5:0]  addr_i = '0;
  logic [15:0] wr_data_i = '0;

  logic        ready_o, rd_valid_o, err_o;
  logic [15:0] rd_data_o;
  logic        r48_ready, r48_rd_valid, r48_err;
  logic [15:0] r48_rd_data;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } rd_exp_t;

  rd_exp_t sb64[$];
  rd_exp_t sb48[$];
  logic [15:0] model64 [64];
  logic [15:0] model48 [48];

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
    logic        exp_err48;
  } vec_t;

  mem_slave u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .wr_rd_i    (wr_rd_i),
    .addr_i     (addr_i),
    .wr_data_i  (wr_data_i),
    .ready_o    (ready_o),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .err_o      (err_o)
  );

  mem_slave #(.DEPTH(48)) u_dut48 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .wr_rd_i    (wr_rd_i),
    .addr_i     (addr_i),
    .wr_data_i  (wr_data_i),
    .ready_o    (r48_ready),
    .rd_data_o  (r48_rd_data),
    .rd_valid_o (r48_rd_valid),
    .err_o      (r48_err)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model64[i] = '0;
    for (int i = 0; i < 48; i++) model48[i] = '0;
  endtask

  task automatic push_read(input logic [5:0] a);
    sb64.push_back('{d: model64[a], e: 1'b0});
    if (a < 6'd48) sb48.push_back('{d: model48[a], e: 1'b0});
    else           sb48.push_back('{d: 16'h0000,   e: 1'b1});
  endtask

  task automatic model_write(input logic [5:0] a, input logic [15:0] d);
    model64[a] = d;
    if (a < 6'd48) model48[a] = d;
  endtask

  // Drive one request at a negedge once ready_o is seen high; returns at the next negedge.
  task automatic issue(input logic wr, input logic [5:0] a, input logic [15:0] d);
    int w;
    w = 0;
    while (ready_o !== 1'b1 && w < 40) begin
      valid_i = 1'b0;
      @(negedge clk_i);
      w++;
    end
    if (ready_o !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_wait: ready_o stuck at %b, required 1", ready_o);
    end
    if (wr) model_write(a, d);
    else    push_read(a);
    valid_i   = 1'b1;
    wr_rd_i   = wr;
    addr_i    = a;
    wr_data_i = d;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb64.size() != 0 || sb48.size() != 0) && w < 40) begin
      @(negedge clk_i);
      w++;
    end
    chk("drain64", sb64.size(), 0);
    chk("drain48", sb48.size(), 0);
  endtask

  // Scoreboard monitor: every read return must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (rd_valid_o) begin
        if (sb64.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_rd_valid64: got 1 required 0");
        end else begin
          rd_exp_t x;
          x = sb64.pop_front();
          chk("rd_data64", rd_data_o, x.d);
          chk("rd_err64", err_o, x.e);
        end
      end
      if (r48_rd_valid) begin
        if (sb48.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_rd_valid48: got 1 required 0");
        end else begin
          rd_exp_t y;
          y = sb48.pop_front();
          chk("rd_data48", r48_rd_data, y.d);
          chk("rd_err48", r48_err, y.e);
        end
      end
    end
  end

  initial begin
    vec_t vecs [15];
    vecs[0]  = '{1'b1, 6'd5,  16'hA5A5, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 6'd5,  16'h0000, 16'hA5A5, 1'b0};
    vecs[2]  = '{1'b1, 6'd7,  16'h1234, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 6'd7,  16'h0000, 16'h1234, 1'b0};
    vecs[4]  = '{1'b0, 6'd0,  16'h0000, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 6'd63, 16'hFFFF, 16'h0000, 1'b1};
    vecs[6]  = '{1'b0, 6'd63, 16'h0000, 16'hFFFF, 1'b1};
    vecs[7]  = '{1'b1, 6'd0,  16'h0001, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 6'd0,  16'h0000, 16'h0001, 1'b0};
    vecs[9]  = '{1'b1, 6'd47, 16'h8000, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 6'd47, 16'h0000, 16'h8000, 1'b0};
    vecs[11] = '{1'b1, 6'd48, 16'h5555, 16'h0000, 1'b1};
    vecs[12] = '{1'b0, 6'd48, 16'h0000, 16'h5555, 1'b1};
    vecs[13] = '{1'b1, 6'd5,  16'h0000, 16'h0000, 1'b0};
    vecs[14] = '{1'b0, 6'd5,  16'h0000, 16'h0000, 1'b0};

    model_clear();

    // Reset state and first ready edge.
    #3;
    chk("rst_ready", ready_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    #1 chk("ready_before_edge", ready_o, 0);
    @(negedge clk_i);
    chk("ready_after_edge", ready_o, 1);

    // Table vectors; reads are checked through the scoreboard.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) begin
        issue(1'b1, vecs[i].addr, vecs[i].data);
        chk("tbl_wr_err64", err_o, 0);
        chk("tbl_wr_err48", r48_err, vecs[i].exp_err48);
      end else begin
        sb64.push_back('{d: vecs[i].exp_rd, e: 1'b0});
        sb48.push_back('{d: vecs[i].exp_err48 ? 16'h0000 : vecs[i].exp_rd, e: vecs[i].exp_err48});
        valid_i = 1'b1; wr_rd_i = 1'b0; addr_i = vecs[i].addr;
        @(negedge clk_i);
        valid_i = 1'b0;
        while (ready_o !== 1'b1 && sb64.size() != 0) @(negedge clk_i);
      end
    end
    drain();

    // Back-to-back writes to every address, ready held high throughout, then read back.
    for (int a = 0; a < 64; a++) begin
      chk("wr_burst_ready", ready_o, 1);
      issue(1'b1, 6'(a), 16'(a * 3));
    end
    for (int a = 0; a < 64; a++) issue(1'b0, 6'(a), 16'h0000);
    drain();

    // Out-of-range on the 48-word instance: write 50, read 50, then 2 must be untouched.
    issue(1'b1, 6'd50, 16'hBEEF);
    chk("oor_wr_err48", r48_err, 1);
    chk("oor_wr_err64", err_o, 0);
    @(negedge clk_i);
    chk("oor_err_pulse_end", r48_err, 0);
    issue(1'b0, 6'd50, 16'h0000);
    issue(1'b0, 6'd2, 16'h0000);
    drain();

    // valid_i held during RD_WAIT with other requests: ignored, nothing queued.
    issue(1'b0, 6'd10, 16'h0000);
    chk("busy_ready_c1", ready_o, 0);
    valid_i = 1'b1; wr_rd_i = 1'b0; addr_i = 6'd12;
    @(negedge clk_i);
    chk("busy_ready_c2", ready_o, 0);
    valid_i = 1'b1; wr_rd_i = 1'b1; addr_i = 6'd11; wr_data_i = 16'hFFFF;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    issue(1'b0, 6'd11, 16'h0000);
    drain();

    // Read latency: write then read addr 5, check per-cycle ready and rd_valid.
    issue(1'b1, 6'd5, 16'hA5A5);
    chk("lat_ready_pre", ready_o, 1);
    push_read(6'd5);
    valid_i = 1'b1; wr_rd_i = 1'b0; addr_i = 6'd5;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      valid_i = 1'b0;
      chk($sformatf("lat_ready_c%0d", k), ready_o, (k == 3) ? 1 : 0);
      chk($sformatf("lat_rd_valid_c%0d", k), rd_valid_o, (k == 3) ? 1 : 0);
    end
    chk("lat_rd_data", rd_data_o, 16'hA5A5);
    @(negedge clk_i);
    chk("lat_pulse_end", rd_valid_o, 0);
    chk("hold_rd_data", rd_data_o, 16'hA5A5);

    // Read immediately after a write to the same address.
    issue(1'b1, 6'd7, 16'h1234);
    issue(1'b0, 6'd7, 16'h0000);
    drain();

    // Reset one cycle into RD_WAIT aborts the read and clears memory.
    issue(1'b0, 6'd5, 16'h0000);
    rst_i = 1'b0;
    #1;
    chk("abort_ready", ready_o, 0);
    chk("abort_rd_valid", rd_valid_o, 0);
    chk("abort_err", err_o, 0);
    chk("abort_rd_data", rd_data_o, 0);
    chk("abort_rd_data48", r48_rd_data, 0);
    sb64.delete();
    sb48.delete();
    model_clear();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    #1 chk("abort_ready_release", ready_o, 0);
    @(negedge clk_i);
    chk("abort_ready_up", ready_o, 1);
    repeat (3) @(negedge clk_i);
    issue(1'b0, 6'd5, 16'h0000);
    issue(1'b0, 6'd40, 16'h0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
